// File: rtl/fp_add_align_pkg.sv
// Shared constants for the adder front end: operand field positions and the
// layout of the aligned magnitude word handed to normalize-and-round.
package fp_add_align_pkg;

  // Default operand format (single precision).
  localparam int unsigned EXPONENT_DEF = 8;
  localparam int unsigned MANTISSA_DEF = 23;

  // Guard bits appended below the fraction in the magnitude word.
  localparam int unsigned GUARD_BITS = 2;

  // Operand field slices for the default format.
  localparam int unsigned SIGN_POS = EXPONENT_DEF + MANTISSA_DEF;
  localparam int unsigned EXP_MSB  = EXPONENT_DEF + MANTISSA_DEF - 1;
  localparam int unsigned EXP_LSB  = MANTISSA_DEF;
  localparam int unsigned FRAC_MSB = MANTISSA_DEF - 1;
  localparam int unsigned FRAC_LSB = 0;

  // Magnitude layout for the default format:
  // [MAG_W-1:MAG_W-2] headroom, [HIDDEN_POS] hidden one, fraction, guard bits.
  localparam int unsigned HIDDEN_POS = MANTISSA_DEF + GUARD_BITS;
  localparam int unsigned MAG_W      = MANTISSA_DEF + 3 + GUARD_BITS;

  // Same quantities for an arbitrary format.
  function automatic int unsigned f_sign_pos(int unsigned e, int unsigned m);
    return e + m;
  endfunction

  function automatic int unsigned f_hidden_pos(int unsigned m);
    return m + GUARD_BITS;
  endfunction

  function automatic int unsigned f_mag_w(int unsigned m);
    return m + 3 + GUARD_BITS;
  endfunction

endpackage

// File: rtl/fp_add_align_if.sv
// Operand and result streams of the adder front end, with valid/ready on each.
interface fp_add_align_if
  import fp_add_align_pkg::*;
#(
  parameter int unsigned EXPONENT = EXPONENT_DEF,
  parameter int unsigned MANTISSA = MANTISSA_DEF
);
  localparam int unsigned OP_W  = EXPONENT + MANTISSA + 1;
  localparam int unsigned MAG_L = f_mag_w(MANTISSA);

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   a_i;
  logic [OP_W-1:0]   b_i;
  logic              out_valid;
  logic              out_ready;
  logic              sum_sign;
  logic [MAG_L-1:0]  sum_unsigned;
  logic [EXPONENT-1:0] sum_exp;

  // Producer of operands / consumer of results.
  modport master (
    output in_valid, a_i, b_i, out_ready,
    input  in_ready, out_valid, sum_sign, sum_unsigned, sum_exp
  );

  // The adder stage itself.
  modport slave (
    input  in_valid, a_i, b_i, out_ready,
    output in_ready, out_valid, sum_sign, sum_unsigned, sum_exp
  );
endinterface

// File: rtl/fp_rshift.sv
// Logarithmic barrel right shifter; counts of W or more give zero.
module fp_rshift #(
  parameter int unsigned W    = 28,
  parameter int unsigned SH_W = 5
) (
  input  logic [W-1:0]    data_i,
  input  logic [SH_W-1:0] shamt_i,
  output logic [W-1:0]    data_o
);

  logic [W-1:0] stage;

  // One conditional power-of-two shift per count bit, then saturate.
  always_comb begin
    stage = data_i;
    for (int unsigned i = 0; i < SH_W; i++) begin
      if (shamt_i[i]) stage = stage >> (1 << i);
    end
    data_o = (32'(shamt_i) >= W) ? '0 : stage;
  end

endmodule

// File: rtl/fp_add_align.sv
// Two-stage add/sub front end: stage 1 orders and aligns operands, stage 2
// shifts the smaller magnitude and adds or subtracts. Elastic on both sides.
module fp_add_align
  import fp_add_align_pkg::*;
#(
  parameter int unsigned EXPONENT = EXPONENT_DEF,
  parameter int unsigned MANTISSA = MANTISSA_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  fp_add_align_if.slave bus
);

  localparam int unsigned SGN    = f_sign_pos(EXPONENT, MANTISSA);
  localparam int unsigned EXP_HI = SGN - 1;
  localparam int unsigned EXP_LO = MANTISSA;
  localparam int unsigned HID    = f_hidden_pos(MANTISSA);
  localparam int unsigned MW     = f_mag_w(MANTISSA);
  localparam int unsigned SAT    = MANTISSA + 3;
  localparam int unsigned SH_W   = $clog2(SAT + 1);

  // Place {hidden, frac} above the guard bits; a zero exponent is a zero.
  function automatic logic [MW-1:0] to_mag(logic [EXPONENT-1:0] e,
                                           logic [MANTISSA-1:0] f);
    logic [MW-1:0] m;
    m = '0;
    if (e != '0) begin
      m[HID] = 1'b1;
      m[GUARD_BITS +: MANTISSA] = f;
    end
    return m;
  endfunction

  // Handshake
  logic s1_valid, s2_valid;
  logic s1_adv, s2_adv;

  assign s2_adv       = !s2_valid || bus.out_ready;
  assign s1_adv       = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv;
  assign bus.out_valid = s2_valid;

  // Stage 1 combinational: order operands by magnitude, clamp exponent gap
  logic                       a_ge_b;
  logic [SGN-1:0]             l_op, s_op;
  logic                       l_sign;
  logic [EXPONENT-1:0]        l_exp, s_exp, gap;
  logic [SH_W-1:0]            gap_sat;
  logic [MW-1:0]              l_mag, s_mag;

  always_comb begin
    a_ge_b  = bus.a_i[SGN-1:0] >= bus.b_i[SGN-1:0];
    l_op    = a_ge_b ? bus.a_i[SGN-1:0] : bus.b_i[SGN-1:0];
    s_op    = a_ge_b ? bus.b_i[SGN-1:0] : bus.a_i[SGN-1:0];
    l_sign  = a_ge_b ? bus.a_i[SGN] : bus.b_i[SGN];
    l_exp   = l_op[EXP_HI:EXP_LO];
    s_exp   = s_op[EXP_HI:EXP_LO];
    gap     = l_exp - s_exp;
    gap_sat = (32'(gap) > SAT) ? SH_W'(SAT) : SH_W'(gap);
    l_mag   = to_mag(l_exp, l_op[MANTISSA-1:0]);
    s_mag   = to_mag(s_exp, s_op[MANTISSA-1:0]);
  end

  // Stage 1 registers
  logic                s1_sign_l, s1_sub;
  logic [EXPONENT-1:0] s1_exp_l;
  logic [MW-1:0]       s1_mag_l, s1_mag_s;
  logic [SH_W-1:0]     s1_gap;

  // Accept a new pair whenever stage 1 can move; clear empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_sign_l <= 1'b0;
      s1_sub    <= 1'b0;
      s1_exp_l  <= '0;
      s1_mag_l  <= '0;
      s1_mag_s  <= '0;
      s1_gap    <= '0;
    end else if (clear) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sign_l <= l_sign;
        s1_sub    <= bus.a_i[SGN] ^ bus.b_i[SGN];
        s1_exp_l  <= l_exp;
        s1_mag_l  <= l_mag;
        s1_mag_s  <= s_mag;
        s1_gap    <= gap_sat;
      end
    end
  end

  // Stage 2 combinational: align and combine
  logic [MW-1:0] s_shifted, sum_raw;

  fp_rshift #(
    .W    (MW),
    .SH_W (SH_W)
  ) u_rshift (
    .data_i  (s1_mag_s),
    .shamt_i (s1_gap),
    .data_o  (s_shifted)
  );

  assign sum_raw = s1_sub ? (s1_mag_l - s_shifted) : (s1_mag_l + s_shifted);

  // Result register; holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid         <= 1'b0;
      bus.sum_sign     <= 1'b0;
      bus.sum_unsigned <= '0;
      bus.sum_exp      <= '0;
    end else if (clear) begin
      s2_valid <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        bus.sum_sign     <= (s1_sub && sum_raw == '0) ? 1'b0 : s1_sign_l;
        bus.sum_unsigned <= sum_raw;
        bus.sum_exp      <= s1_exp_l;
      end
    end
  end

endmodule

// File: tb/tb_fp_add_align.sv
// Bench for fp_add_align: directed literal cases, a toggled-ready stream,
// randomized traffic with clears, and reset/clear flushes, all compared
// against an arithmetic reference model.
module tb_fp_add_align;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;

  fp_add_align_if #(.EXPONENT(8), .MANTISSA(23)) bus ();

  fp_add_align #(.EXPONENT(8), .MANTISSA(23)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int delivered = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint unsigned act,
                     input longint unsigned req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: real-valued ordering by {exp,frac}, then integer arithmetic
  // on the scaled significands. Returns {sign, exp[7:0], mag[27:0]}.
  function automatic logic [36:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] l, s;
    longint unsigned ml, ms, sh, r;
    int unsigned el, es, d;
    bit sub, sg;
    if (a[30:0] >= b[30:0]) begin l = a; s = b; end
    else begin l = b; s = a; end
    el = l[30:23];
    es = s[30:23];
    ml = (el == 0) ? 0 : (longint'(8388608) + longint'(l[22:0])) * 4;
    ms = (es == 0) ? 0 : (longint'(8388608) + longint'(s[22:0])) * 4;
    d  = el - es;
    sh = (d >= 26) ? 0 : (ms >> d);
    sub = a[31] ^ b[31];
    r  = sub ? (ml - sh) : (ml + sh);
    sg = (sub && r == 0) ? 1'b0 : l[31];
    return {sg, el[7:0], r[27:0]};
  endfunction

  function automatic logic [31:0] mk(input bit s, input int e, input logic [22:0] f);
    logic [7:0] e8;
    logic [22:0] ff;
    e8 = e[7:0];
    ff = (e == 0) ? 23'd0 : f;
    return {s, e8, ff};
  endfunction

  function automatic logic [31:0] rand_op(input int near_exp);
    int e;
    if (near_exp < 0) e = $urandom_range(0, 255);
    else e = near_exp + $urandom_range(0, 32) - 16;
    if (e < 0) e = 0;
    if (e > 255) e = 255;
    if ($urandom_range(0, 19) == 0) e = 0;
    return mk($urandom_range(0, 1), e, 23'($urandom));
  endfunction

  // Scoreboard monitor
  logic [36:0] exp_q[$];
  int          acc_q[$];
  bit          stalled = 0;
  logic [36:0] held;

  always @(negedge clk) begin
    logic [36:0] e;
    int t;
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
      stalled = 0;
      chk("reset_out_valid", bus.out_valid, 0);
      chk("reset_outputs", {bus.sum_sign, bus.sum_exp, bus.sum_unsigned}, 0);
    end else begin
      chk("in_ready", bus.in_ready, !(exp_q.size() >= 2 && !bus.out_ready));
      if (stalled && bus.out_valid)
        chk("stall_stable", {bus.sum_sign, bus.sum_exp, bus.sum_unsigned}, held);
      if (bus.out_valid) begin
        chk("valid_with_pending", exp_q.size() > 0, 1);
        if (bus.out_ready && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          t = acc_q.pop_front();
          delivered++;
          chk("sum_sign", bus.sum_sign, e[36]);
          chk("sum_exp", bus.sum_exp, e[35:28]);
          chk("sum_unsigned", bus.sum_unsigned, e[27:0]);
          chk("latency_min", (cyc - t) >= 2, 1);
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      held = {bus.sum_sign, bus.sum_exp, bus.sum_unsigned};
      if (bus.in_valid && bus.in_ready && !clear) begin
        exp_q.push_back(ref_add(bus.a_i, bus.b_i));
        acc_q.push_back(cyc);
      end
      if (clear) begin
        exp_q.delete();
        acc_q.delete();
      end
    end
  end

  // One isolated operation with out_ready=1; literal expectations at exactly 2 cycles.
  task automatic one(input string name, input logic [31:0] a, input logic [31:0] b,
                     input bit s, input logic [7:0] e, input logic [27:0] m);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.a_i = a;
    bus.b_i = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk({name, "_not_yet"}, bus.out_valid, 0);
    @(posedge clk); #1;
    chk({name, "_valid"}, bus.out_valid, 1);
    chk({name, "_sign"}, bus.sum_sign, s);
    chk({name, "_exp"}, bus.sum_exp, e);
    chk({name, "_mag"}, bus.sum_unsigned, m);
  endtask

  task automatic stream(input int n_ops, input int max_cyc, input bit toggle, input int clr_pct);
    int sent, cycles, ph;
    bit acc;
    logic [31:0] a, b;
    sent = 0; cycles = 0; acc = 0;
    a = rand_op(-1);
    b = rand_op(a[30:23]);
    while (cycles < max_cyc) begin
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        a = rand_op(-1);
        b = ($urandom_range(0, 7) == 0) ? {1'($urandom_range(0, 1)), a[30:0]} : rand_op(a[30:23]);
      end
      if (sent >= n_ops) break;
      ph = cycles % 4;
      bus.out_ready = toggle ? (ph == 0 || ph == 3) : ($urandom_range(0, 99) < 60);
      bus.in_valid  = toggle ? 1'b1 : ($urandom_range(0, 99) < 70);
      clear = ($urandom_range(0, 99) < clr_pct);
      bus.a_i = a;
      bus.b_i = b;
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready && !clear;
      cycles++;
    end
    bus.in_valid = 1'b0;
    clear = 1'b0;
    bus.out_ready = 1'b1;
    chk("stream_budget", sent >= n_ops, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill_two();
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.a_i = 32'h3F800000;
    bus.b_i = 32'h40400000;
    @(posedge clk); #1;
    bus.a_i = 32'h40A00000;
    bus.b_i = 32'hBF800000;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("fill_out_valid", bus.out_valid, 1);
    chk("fill_in_ready_full", bus.in_ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;
    bus.in_valid = 1'b0;
    bus.a_i = '0;
    bus.b_i = '0;
    bus.out_ready = 1'b1;
    #1;
    chk("por_out_valid", bus.out_valid, 0);
    chk("por_outputs", {bus.sum_sign, bus.sum_exp, bus.sum_unsigned}, 0);
    idle(3);
    rst_n = 1'b1;
    #1;
    chk("post_reset_in_ready", bus.in_ready, 1);

    one("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 8'h7F, 28'h4000000);
    one("one_plus_two", 32'h3F800000, 32'h40000000, 1'b0, 8'h80, 28'h3000000);
    one("two_plus_one", 32'h40000000, 32'h3F800000, 1'b0, 8'h80, 28'h3000000);
    one("cancel",       32'h3F800000, 32'hBF800000, 1'b0, 8'h7F, 28'h0000000);
    one("one_minus_two", 32'h3F800000, 32'hC0000000, 1'b1, 8'h80, 28'h1000000);
    one("gap30",        32'h3F800000, 32'h30800000, 1'b0, 8'h7F, 28'h2000000);
    one("zero_plus_one", 32'h00000000, 32'h3F800000, 1'b0, 8'h7F, 28'h2000000);

    // Eight pairs with out_ready cycling 1,0,0,1
    idle(3);
    d0 = delivered;
    stream(8, 100, 1'b1, 0);
    idle(6);
    chk("stream_delivered", delivered - d0, 8);

    // Reset with both stages full
    fill_two();
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_valid", bus.out_valid, 0);
    chk("async_reset_outputs", {bus.sum_sign, bus.sum_exp, bus.sum_unsigned}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    d0 = delivered;
    idle(4);
    one("after_reset", 32'h40000000, 32'h40000000, 1'b0, 8'h80, 28'h4000000);

    // Clear with both stages full and an input offered
    idle(2);
    fill_two();
    clear = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    bus.in_valid = 1'b0;
    chk("clear_valid", bus.out_valid, 0);
    bus.out_ready = 1'b1;
    idle(4);

    // Clear with one in flight and an acceptable input offered in the clear cycle
    bus.in_valid = 1'b1;
    bus.a_i = 32'h3F800000;
    bus.b_i = 32'h3F800000;
    @(posedge clk); #1;
    clear = 1'b1;
    bus.a_i = 32'h40000000;
    @(posedge clk); #1;
    clear = 1'b0;
    bus.in_valid = 1'b0;
    chk("clear2_valid", bus.out_valid, 0);
    idle(4);
    chk("clear_nothing_emitted", delivered - d0, 1);
    one("after_clear", 32'hC0400000, 32'h3F800000, 1'b1, 8'h80, 28'h2000000);

    // Randomized traffic with occasional clears
    idle(2);
    stream(300, 1500, 1'b0, 3);
    idle(8);
    chk("drain_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
